// File: rtl/stopwatch_core.sv
// rtl/stopwatch_core.sv - minutes/seconds stopwatch with prescaler, pause, saturating overflow
// Optional lap capture is built only when STOPWATCH_LAP_EN is defined.
module stopwatch_core #(
   parameter int CLK_HZ  = 1000,
   parameter int MIN_W   = 8,
   parameter int MAX_MIN = 99
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             stop,
   input  logic             clear,
   input  logic             lap,
   output logic [MIN_W-1:0] minutes,
   output logic [5:0]       seconds,
   output logic [MIN_W-1:0] lap_minutes,
   output logic [5:0]       lap_seconds,
   output logic             lap_valid,
   output logic [1:0]       status,
   output logic             overflow
);

   localparam int PW = $clog2(CLK_HZ);

   typedef enum logic [1:0] {
      S_IDLE   = 2'b00,
      S_RUN    = 2'b01,
      S_PAUSED = 2'b10,
      S_OVF    = 2'b11
   } state_t;

   state_t        state;
   state_t        state_nx;
   logic [PW-1:0] presc;
   logic          tick;
   logic          terminal;

   assign tick     = (state == S_RUN) && (presc == PW'(CLK_HZ - 1));
   assign terminal = tick && (minutes == MIN_W'(MAX_MIN)) && (seconds == 6'd59);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Stop beats start, so a simultaneous start/stop never resumes counting.
   always_comb begin
      state_nx = state;
      if (clear) begin
         state_nx = S_IDLE;
      end else begin
         case (state)
            S_IDLE:   if (start && !stop) state_nx = S_RUN;
            S_RUN:    if (terminal) state_nx = S_OVF;
                      else if (stop) state_nx = S_PAUSED;
            S_PAUSED: if (start && !stop) state_nx = S_RUN;
            default:  state_nx = state;
         endcase
      end
   end

   assign status = state;

   // The prescaler only advances in RUN, so a pause keeps the sub-second fraction.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc    <= '0;
         seconds  <= '0;
         minutes  <= '0;
         overflow <= 1'b0;
      end else if (clear) begin
         presc    <= '0;
         seconds  <= '0;
         minutes  <= '0;
         overflow <= 1'b0;
      end else if (state == S_RUN) begin
         if (tick) begin
            presc <= '0;
            if (terminal) begin
               overflow <= 1'b1;
            end else if (seconds == 6'd59) begin
               seconds <= '0;
               minutes <= minutes + 1'b1;
            end else begin
               seconds <= seconds + 1'b1;
            end
         end else begin
            presc <= presc + 1'b1;
         end
      end
   end

`ifdef STOPWATCH_LAP_EN
   logic lap_take;

   assign lap_take = lap && !clear && (state != S_IDLE);

   // Captures the pre-tick value held in the counters during the lap cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lap_minutes <= '0;
         lap_seconds <= '0;
         lap_valid   <= 1'b0;
      end else if (clear) begin
         lap_minutes <= '0;
         lap_seconds <= '0;
         lap_valid   <= 1'b0;
      end else begin
         lap_valid <= lap_take;
         if (lap_take) begin
            lap_minutes <= minutes;
            lap_seconds <= seconds;
         end
      end
   end
`else
   logic unused_lap;

   assign unused_lap  = lap;
   assign lap_minutes = '0;
   assign lap_seconds = '0;
   assign lap_valid   = 1'b0;
`endif

endmodule

// File: tb/tb_stopwatch_core.sv
// tb/tb_stopwatch_core.sv - self-checking bench for stopwatch_core (CLK_HZ=4, MAX_MIN=2)
// Lap expectations follow STOPWATCH_LAP_EN.
module tb_stopwatch_core;

   localparam int CLK_HZ  = 4;
   localparam int MIN_W   = 8;
   localparam int MAX_MIN = 2;
   localparam int LIMIT   = MAX_MIN * 60 + 59;
`ifdef STOPWATCH_LAP_EN
   localparam bit LAP_EN = 1'b1;
`else
   localparam bit LAP_EN = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst_n = 1'b1;
   logic             start = 1'b0;
   logic             stop = 1'b0;
   logic             clear = 1'b0;
   logic             lap = 1'b0;
   logic [MIN_W-1:0] minutes;
   logic [5:0]       seconds;
   logic [MIN_W-1:0] lap_minutes;
   logic [5:0]       lap_seconds;
   logic             lap_valid;
   logic [1:0]       status;
   logic             overflow;

   int compared = 0;
   int mismatched = 0;

   stopwatch_core #(.CLK_HZ(CLK_HZ), .MIN_W(MIN_W), .MAX_MIN(MAX_MIN)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .clear(clear), .lap(lap),
      .minutes(minutes), .seconds(seconds), .lap_minutes(lap_minutes),
      .lap_seconds(lap_seconds), .lap_valid(lap_valid), .status(status), .overflow(overflow)
   );

   always #5 clk = ~clk;

   // Model: elapsed time is simply total RUN cycles since clear, divided and saturated.
   int       m_cycles = 0;
   int       m_lap = 0;
   bit       m_lapv = 1'b0;
   int       m_state = 0;

   function automatic int disp_total(input int c);
      int s;
      s = c / CLK_HZ;
      return (s > LIMIT) ? LIMIT : s;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_cycles <= 0; m_lap <= 0; m_lapv <= 1'b0; m_state <= 0;
      end else if (clear) begin
         m_cycles <= 0; m_lap <= 0; m_lapv <= 1'b0; m_state <= 0;
      end else begin
         m_lapv <= LAP_EN && lap && (m_state != 0);
         if (LAP_EN && lap && (m_state != 0)) m_lap <= disp_total(m_cycles);
         case (m_state)
            0: if (start && !stop) m_state <= 1;
            1: begin
               m_cycles <= m_cycles + 1;
               if ((m_cycles + 1) / CLK_HZ > LIMIT) m_state <= 3;
               else if (stop) m_state <= 2;
            end
            2: if (start && !stop) m_state <= 1;
            default: ;
         endcase
      end
   end

   task automatic check(input string name, input int got, input int want);
      compared++;
      if (got != want) begin
         mismatched++;
         $display("FAIL %s got %0d want %0d at %0t", name, got, want, $time);
      end
   endtask

   always @(negedge clk) begin
      check("minutes", int'(minutes), disp_total(m_cycles) / 60);
      check("seconds", int'(seconds), disp_total(m_cycles) % 60);
      check("status", int'(status), m_state);
      check("overflow", int'(overflow), int'(m_state == 3));
      check("lap_minutes", int'(lap_minutes), m_lap / 60);
      check("lap_seconds", int'(lap_seconds), m_lap % 60);
      check("lap_valid", int'(lap_valid), int'(m_lapv));
   end

   task automatic cmd(input bit s, input bit p, input bit c, input bit l);
      start = s; stop = p; clear = c; lap = l;
      @(negedge clk);
      start = 1'b0; stop = 1'b0; clear = 1'b0; lap = 1'b0;
   endtask

   task automatic wait_n(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      #1 rst_n = 1'b0;
      #2;
      check("rst_status", int'(status), 0);
      check("rst_seconds", int'(seconds), 0);
      check("rst_minutes", int'(minutes), 0);
      @(negedge clk);
      rst_n = 1'b1;

      // start, first ticks
      cmd(1, 0, 0, 0);
      check("run_status", int'(status), 1);
      wait_n(3);
      check("pre_tick_sec", int'(seconds), 0);
      wait_n(1);
      check("first_tick_sec", int'(seconds), 1);
      wait_n(4);
      check("second_tick_sec", int'(seconds), 2);

      // pause keeps fraction
      cmd(0, 0, 1, 0);
      cmd(1, 0, 0, 0);
      wait_n(1);
      cmd(0, 1, 0, 0);
      check("pause_status", int'(status), 2);
      wait_n(10);
      check("pause_hold_status", int'(status), 2);
      check("pause_hold_sec", int'(seconds), 0);
      cmd(1, 0, 0, 0);
      wait_n(1);
      check("resume_sec0", int'(seconds), 0);
      wait_n(1);
      check("resume_sec1", int'(seconds), 1);

      // minute rollover and overflow
      cmd(0, 0, 1, 0);
      cmd(1, 0, 0, 0);
      wait_n(240);
      check("roll_min", int'(minutes), 1);
      check("roll_sec", int'(seconds), 0);
      wait_n(476);
      check("max_min", int'(minutes), 2);
      check("max_sec", int'(seconds), 59);
      check("max_status", int'(status), 1);
      wait_n(4);
      check("ovf_status", int'(status), 3);
      check("ovf_flag", int'(overflow), 1);
      check("ovf_min", int'(minutes), 2);
      check("ovf_sec", int'(seconds), 59);
      cmd(1, 0, 0, 0);
      cmd(0, 1, 0, 0);
      wait_n(8);
      check("ovf_sticky", int'(status), 3);
      check("ovf_hold_sec", int'(seconds), 59);
      cmd(0, 0, 1, 0);
      check("clr_status", int'(status), 0);
      check("clr_ovf", int'(overflow), 0);
      check("clr_min", int'(minutes), 0);

      // coincident commands
      cmd(1, 1, 0, 0);
      check("startstop_idle", int'(status), 0);
      cmd(1, 0, 0, 0);
      wait_n(5);
      cmd(0, 1, 1, 0);
      check("clrstop_status", int'(status), 0);
      check("clrstop_sec", int'(seconds), 0);

      // lap in the tick cycle at 0:03
      cmd(1, 0, 0, 0);
      wait_n(15);
      cmd(0, 0, 0, 1);
      check("lap_counter", int'(seconds), 4);
      check("lap_sec", int'(lap_seconds), LAP_EN ? 3 : 0);
      check("lap_vld", int'(lap_valid), int'(LAP_EN));
      wait_n(1);
      check("lap_vld_drop", int'(lap_valid), 0);
      cmd(0, 0, 0, 1);
      cmd(0, 0, 0, 1);
      cmd(0, 1, 0, 1);
      cmd(0, 0, 0, 1);
      wait_n(2);
      cmd(0, 0, 1, 0);
      cmd(0, 0, 0, 1);
      check("lap_idle_vld", int'(lap_valid), 0);
      check("lap_idle_sec", int'(lap_seconds), 0);

      // async reset mid-run at 1:17
      cmd(1, 0, 0, 0);
      wait_n(77 * 4);
      check("pre_rst_min", int'(minutes), 1);
      check("pre_rst_sec", int'(seconds), 17);
      #2 rst_n = 1'b0;
      #1;
      check("arst_min", int'(minutes), 0);
      check("arst_sec", int'(seconds), 0);
      check("arst_status", int'(status), 0);
      @(negedge clk);
      rst_n = 1'b1;
      wait_n(6);
      check("post_rst_status", int'(status), 0);
      check("post_rst_sec", int'(seconds), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
